// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V sequencer: steps the shared datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// traps illegal opcodes and memory timeouts, and counts retired instructions.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           OP_i,
  input  logic                 Mem_Ready_i,
  output logic                 PC_Write_o,
  output logic                 IR_Write_o,
  output logic                 IorD_o,
  output logic                 Mem_Read_o,
  output logic                 Mem_Write_o,
  output logic                 Reg_Write_o,
  output logic                 Mem_to_Reg_o,
  output logic                 ALU_Src_o,
  output logic                 Branch_o,
  output logic                 Jump_o,
  output logic [2:0]           ALU_Op_o,
  output logic [2:0]           State_o,
  output logic                 Error_o,
  output logic [CNT_WIDTH-1:0] Instr_Count_o
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_U    = 7'h37;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_ERROR     = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   known_op, is_load, is_store, is_jump;

  always_comb begin
    known_op = (OP_i == OP_R) || (OP_i == OP_I) || (OP_i == OP_U) || (OP_i == OP_B) ||
               (OP_i == OP_JALR) || (OP_i == OP_S) || (OP_i == OP_LOAD) || (OP_i == OP_JAL);
    is_load  = (OP_i == OP_LOAD);
    is_store = (OP_i == OP_S);
    is_jump  = (OP_i == OP_JAL) || (OP_i == OP_JALR);
  end

  // Wait counter is zero outside FETCH/MEM, so every entry into those states starts from zero.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (Mem_Ready_i) begin
          if (state_q == S_FETCH) state_d = S_DECODE;
          else                    state_d = is_load ? S_WRITEBACK : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE:    state_d = known_op ? S_EXECUTE : S_ERROR;
      S_EXECUTE: begin
        if (OP_i == OP_B)            state_d = S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_ERROR;
    endcase
    cnt_d = cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    IorD_o       = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    Mem_to_Reg_o = 1'b0;
    ALU_Src_o    = 1'b0;
    Branch_o     = 1'b0;
    Jump_o       = 1'b0;
    ALU_Op_o     = 3'b000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          Mem_Read_o = 1'b1;
          IR_Write_o = Mem_Ready_i;
          PC_Write_o = Mem_Ready_i;
        end
        S_EXECUTE: begin
          case (OP_i)
            OP_I:    ALU_Op_o = 3'b001;
            OP_U:    ALU_Op_o = 3'b010;
            OP_B:    ALU_Op_o = 3'b011;
            OP_JALR: ALU_Op_o = 3'b100;
            OP_S:    ALU_Op_o = 3'b101;
            OP_LOAD: ALU_Op_o = 3'b110;
            OP_JAL:  ALU_Op_o = 3'b111;
            default: ALU_Op_o = 3'b000;
          endcase
          ALU_Src_o  = !(OP_i == OP_R || OP_i == OP_B);
          Branch_o   = (OP_i == OP_B);
          Jump_o     = is_jump;
          PC_Write_o = is_jump;
        end
        S_MEM: begin
          IorD_o      = 1'b1;
          Mem_Read_o  = is_load;
          Mem_Write_o = is_store;
        end
        S_WRITEBACK: begin
          Reg_Write_o  = 1'b1;
          Mem_to_Reg_o = is_load;
        end
        default: ;
      endcase
    end
  end

  assign State_o       = state_q;
  assign Error_o       = (state_q == S_ERROR);
  assign Instr_Count_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand sequences for traps and reset.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  OP_i;
  logic        Mem_Ready_i;
  logic        PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, Reg_Write_o;
  logic        Mem_to_Reg_o, ALU_Src_o, Branch_o, Jump_o, Error_o;
  logic [2:0]  ALU_Op_o, State_o;
  logic [31:0] Instr_Count_o;

  multicycle_control #(.WAIT_LIMIT(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .Mem_Ready_i(Mem_Ready_i),
    .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o), .IorD_o(IorD_o),
    .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Reg_Write_o(Reg_Write_o),
    .Mem_to_Reg_o(Mem_to_Reg_o), .ALU_Src_o(ALU_Src_o), .Branch_o(Branch_o),
    .Jump_o(Jump_o), .ALU_Op_o(ALU_Op_o), .State_o(State_o), .Error_o(Error_o),
    .Instr_Count_o(Instr_Count_o)
  );

  always #5 clk = ~clk;

  // strobe order: PC_Write IR_Write IorD Mem_Read Mem_Write Reg_Write Mem_to_Reg ALU_Src Branch Jump
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [9:0]  strb;
    logic [2:0]  aluop;
    logic [2:0]  st;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic rst, input logic [6:0] op, input logic rdy, input logic [9:0] strb,
                     input logic [2:0] aluop, input logic [2:0] st, input logic err, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.strb = strb; v.aluop = aluop;
    v.st = st; v.err = err; v.cnt = cnt;
    vq.push_back(v);
  endtask

  function automatic logic [9:0] strobes();
    return {PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
            Mem_to_Reg_o, ALU_Src_o, Branch_o, Jump_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic [9:0] strb, input logic [2:0] aluop,
                           input logic [2:0] st, input logic err, input logic [31:0] cnt);
    chk({name, ".ctl"}, {51'd0, strobes(), ALU_Op_o}, {51'd0, strb, aluop});
    chk({name, ".state"}, {61'd0, State_o}, {61'd0, st});
    chk({name, ".err_cnt"}, {31'd0, Error_o, Instr_Count_o}, {31'd0, err, cnt});
  endtask

  // Drive at the falling edge, sample 2 time units later, state advances at the next rising edge.
  task automatic drive(input logic rst, input logic [6:0] op, input logic rdy);
    @(negedge clk);
    reset = rst; OP_i = op; Mem_Ready_i = rdy;
    #2;
  endtask

  localparam logic [9:0] Z    = 10'b0000000000;
  localparam logic [9:0] FRDY = 10'b1101000000;
  localparam logic [9:0] FWT  = 10'b0001000000;
  localparam logic [9:0] SRC  = 10'b0000000100;
  localparam logic [9:0] WB   = 10'b0000010000;
  localparam logic [9:0] WBL  = 10'b0000011000;
  localparam logic [9:0] MRD  = 10'b0011000000;
  localparam logic [9:0] MWR  = 10'b0010100000;
  localparam logic [9:0] JMP  = 10'b1000000101;
  localparam logic [9:0] BRN  = 10'b0000000010;

  initial begin
    reset = 1'b1; OP_i = 7'h33; Mem_Ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then R-type
    add(1, 7'h33, 1, Z,    3'b000, 3'd0, 0, 0);
    add(0, 7'h33, 1, FRDY, 3'b000, 3'd0, 0, 0);
    add(0, 7'h33, 1, Z,    3'b000, 3'd1, 0, 0);
    add(0, 7'h33, 1, Z,    3'b000, 3'd2, 0, 0);
    add(0, 7'h33, 1, WB,   3'b000, 3'd4, 0, 0);
    // LOAD with one fetch wait and three memory waits
    add(0, 7'h03, 0, FWT,  3'b000, 3'd0, 0, 1);
    add(0, 7'h03, 1, FRDY, 3'b000, 3'd0, 0, 1);
    add(0, 7'h03, 1, Z,    3'b000, 3'd1, 0, 1);
    add(0, 7'h03, 1, SRC,  3'b110, 3'd2, 0, 1);
    add(0, 7'h03, 0, MRD,  3'b000, 3'd3, 0, 1);
    add(0, 7'h03, 0, MRD,  3'b000, 3'd3, 0, 1);
    add(0, 7'h03, 0, MRD,  3'b000, 3'd3, 0, 1);
    add(0, 7'h03, 1, MRD,  3'b000, 3'd3, 0, 1);
    add(0, 7'h03, 1, WBL,  3'b000, 3'd4, 0, 1);
    // B-type
    add(0, 7'h63, 1, FRDY, 3'b000, 3'd0, 0, 2);
    add(0, 7'h63, 1, Z,    3'b000, 3'd1, 0, 2);
    add(0, 7'h63, 1, BRN,  3'b011, 3'd2, 0, 2);
    // STORE
    add(0, 7'h23, 1, FRDY, 3'b000, 3'd0, 0, 3);
    add(0, 7'h23, 1, Z,    3'b000, 3'd1, 0, 3);
    add(0, 7'h23, 1, SRC,  3'b101, 3'd2, 0, 3);
    add(0, 7'h23, 1, MWR,  3'b000, 3'd3, 0, 3);
    // JAL, JALR, I-logic, U
    add(0, 7'h6F, 1, FRDY, 3'b000, 3'd0, 0, 4);
    add(0, 7'h6F, 1, Z,    3'b000, 3'd1, 0, 4);
    add(0, 7'h6F, 1, JMP,  3'b111, 3'd2, 0, 4);
    add(0, 7'h6F, 1, WB,   3'b000, 3'd4, 0, 4);
    add(0, 7'h67, 1, FRDY, 3'b000, 3'd0, 0, 5);
    add(0, 7'h67, 1, Z,    3'b000, 3'd1, 0, 5);
    add(0, 7'h67, 1, JMP,  3'b100, 3'd2, 0, 5);
    add(0, 7'h67, 1, WB,   3'b000, 3'd4, 0, 5);
    add(0, 7'h13, 1, FRDY, 3'b000, 3'd0, 0, 6);
    add(0, 7'h13, 1, Z,    3'b000, 3'd1, 0, 6);
    add(0, 7'h13, 1, SRC,  3'b001, 3'd2, 0, 6);
    add(0, 7'h13, 1, WB,   3'b000, 3'd4, 0, 6);
    add(0, 7'h37, 1, FRDY, 3'b000, 3'd0, 0, 7);
    add(0, 7'h37, 1, Z,    3'b000, 3'd1, 0, 7);
    add(0, 7'h37, 1, SRC,  3'b010, 3'd2, 0, 7);
    add(0, 7'h37, 1, WB,   3'b000, 3'd4, 0, 7);
    add(0, 7'h33, 0, FWT,  3'b000, 3'd0, 0, 8);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].op, vq[i].rdy);
      check_all($sformatf("vec%0d", i), vq[i].strb, vq[i].aluop, vq[i].st, vq[i].err, vq[i].cnt);
    end

    // illegal opcode: DECODE then absorbing ERROR, then reset clears everything
    drive(0, 7'h7F, 1);
    drive(0, 7'h7F, 1);
    chk("illegal.decode", {61'd0, State_o}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 7'h7F, 1);
      check_all($sformatf("illegal.err%0d", i), Z, 3'b000, 3'd7, 1, 8);
    end
    drive(1, 7'h33, 1);
    check_all("illegal.rst_hi", Z, 3'b000, 3'd7, 1, 8);
    drive(0, 7'h33, 0);
    check_all("illegal.rst_done", FWT, 3'b000, 3'd0, 0, 0);

    // fetch timeout: 15 waiting cycles in FETCH, then ERROR
    drive(1, 7'h33, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 7'h33, 0);
      check_all($sformatf("timeout.wait%0d", i), FWT, 3'b000, 3'd0, 0, 0);
    end
    drive(0, 7'h33, 0);
    check_all("timeout.err", Z, 3'b000, 3'd7, 1, 0);

    // reset during MEM of a store with ready high: abandoned, not retired
    drive(1, 7'h63, 1);
    drive(0, 7'h63, 1);
    drive(0, 7'h63, 1);
    drive(0, 7'h63, 1);
    drive(0, 7'h23, 1);
    chk("mrst.count_before", {32'd0, Instr_Count_o}, 64'd1);
    drive(0, 7'h23, 1);
    drive(0, 7'h23, 1);
    drive(0, 7'h23, 0);
    check_all("mrst.mem", MWR, 3'b000, 3'd3, 0, 1);
    drive(1, 7'h23, 1);
    check_all("mrst.rst_hi", Z, 3'b000, 3'd3, 0, 1);
    drive(0, 7'h23, 0);
    check_all("mrst.after", FWT, 3'b000, 3'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
